// File: rtl/gp_pkg.sv
// rtl/gp_pkg.sv - shared widths and FSM state type for the grasshopper job arbiter
// Contents: GP_KEY_W (job word width), GP_BLK_W (result width), GP_CNT_W (bit counter width),
//           gp_state_e (arbiter FSM states).
package gp_pkg;

    localparam int GP_KEY_W = 256;
    localparam int GP_BLK_W = 128;
    localparam int GP_CNT_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } gp_state_e;

endpackage

// File: rtl/gp_deser.sv
// rtl/gp_deser.sv - serial-to-parallel collector for the core's result bits
// Ports: clk, reset (sync, active-high), clr (start of a new job), bit_i / vld_i (serial bit and
//        its qualifier), data_o (128-bit word, first bit ends in the MSB), done_o (high while
//        the 128th valid bit is being accepted).
module gp_deser
    import gp_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                bit_i,
    input  logic                vld_i,
    output logic [GP_BLK_W-1:0] data_o,
    output logic                done_o
);

    logic [GP_CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt    <= '0;
            data_o <= '0;
        end else if (vld_i) begin
            data_o <= {data_o[GP_BLK_W-2:0], bit_i};
            cnt    <= cnt + 1'b1;
        end
    end

    // The counter sits at all-ones while the 128th bit is on the input, so the FSM can
    // leave RUN on the same edge that shifts that bit in.
    assign done_o = vld_i && (cnt == '1);

endmodule

// File: rtl/gp_arbiter.sv
// rtl/gp_arbiter.sv - two-requester round-robin front end for one grasshopper core
// Ports: clk, reset (sync, active-high); in_valid/in_ready[1:0], in_data0/in_data1 (job words);
//        core_load, core_data (to core), core_busy, core_dout, core_dout_vld (from core);
//        out_valid/out_ready, out_data, out_id, out_err (result channel).
module gp_arbiter
    import gp_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          in_valid,
    output logic [1:0]          in_ready,
    input  logic [GP_KEY_W-1:0] in_data0,
    input  logic [GP_KEY_W-1:0] in_data1,
    output logic                core_load,
    output logic [GP_KEY_W-1:0] core_data,
    input  logic                core_busy,
    input  logic                core_dout,
    input  logic                core_dout_vld,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [GP_BLK_W-1:0] out_data,
    output logic                out_id,
    output logic                out_err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    gp_state_e           state;
    gp_state_e           state_next;
    logic                last_grant;
    logic                grant_id;
    logic                grant;
    logic [WD_W-1:0]     wd;
    logic                wd_expired;
    logic [GP_BLK_W-1:0] deser_data;
    logic                deser_done;

    // Core busy is informational only; job progress is tracked by the bit count and watchdog.
    logic unused_busy;
    assign unused_busy = core_busy;

    // When both request, the one that was not served last wins; otherwise the lone requester.
    always_comb begin
        grant_id = in_valid[1];
        if (in_valid == 2'b11) begin
            grant_id = ~last_grant;
        end
    end

    assign grant      = (state == IDLE) && (|in_valid);
    assign wd_expired = (wd == WD_W'(TIMEOUT - 1));

    always_comb begin
        state_next = state;
        in_ready   = 2'b00;
        case (state)
            IDLE: begin
                if (grant) begin
                    in_ready[grant_id] = 1'b1;
                    state_next         = LOAD;
                end
            end
            LOAD: state_next = RUN;
            RUN: begin
                if (deser_done || wd_expired) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            core_data  <= '0;
            out_id     <= 1'b0;
            out_err    <= 1'b0;
            last_grant <= 1'b1;
            wd         <= '0;
        end else begin
            state <= state_next;
            if (grant) begin
                core_data <= grant_id ? in_data1 : in_data0;
                out_id    <= grant_id;
                out_err   <= 1'b0;
                wd        <= '0;
            end
            if (state == RUN) begin
                wd <= wd + 1'b1;
                // A final bit arriving on the expiry cycle still counts as a good result.
                if (wd_expired && !deser_done) begin
                    out_err <= 1'b1;
                end
            end
            if ((state == DONE) && out_ready) begin
                last_grant <= out_id;
            end
        end
    end

    gp_deser u_deser (
        .clk    (clk),
        .reset  (reset),
        .clr    (grant),
        .bit_i  (core_dout),
        .vld_i  (core_dout_vld && (state == RUN)),
        .data_o (deser_data),
        .done_o (deser_done)
    );

    assign core_load = (state == LOAD);
    assign out_valid = (state == DONE);
    assign out_data  = (out_valid && !out_err) ? deser_data : '0;

endmodule

// File: tb/tb_gp_arbiter.sv
// tb/tb_gp_arbiter.sv - directed self-checking bench for gp_arbiter
module tb_gp_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   in_valid;
    logic [1:0]   in_ready;
    logic [255:0] in_data0, in_data1;
    logic         core_load;
    logic [255:0] core_data;
    logic         core_busy;
    logic         core_dout, core_dout_vld;
    logic         out_valid, out_ready;
    logic [127:0] out_data;
    logic         out_id, out_err;

    logic [1:0]   t_in_valid;
    logic [1:0]   t_in_ready;
    logic [255:0] t_in_data0, t_in_data1;
    logic         t_core_load;
    logic [255:0] t_core_data;
    logic         t_core_dout, t_core_dout_vld;
    logic         t_out_valid, t_out_ready;
    logic [127:0] t_out_data;
    logic         t_out_id, t_out_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gp_arbiter dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data0(in_data0), .in_data1(in_data1), .core_load(core_load),
        .core_data(core_data), .core_busy(core_busy), .core_dout(core_dout),
        .core_dout_vld(core_dout_vld), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id), .out_err(out_err)
    );

    gp_arbiter #(.TIMEOUT(50)) dut_to (
        .clk(clk), .reset(reset), .in_valid(t_in_valid), .in_ready(t_in_ready),
        .in_data0(t_in_data0), .in_data1(t_in_data1), .core_load(t_core_load),
        .core_data(t_core_data), .core_busy(core_busy), .core_dout(t_core_dout),
        .core_dout_vld(t_core_dout_vld), .out_valid(t_out_valid), .out_ready(t_out_ready),
        .out_data(t_out_data), .out_id(t_out_id), .out_err(t_out_err)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [127:0] w, input bit gapped, input int nbits);
        for (int i = 127; i > 127 - nbits; i--) begin
            core_dout     = w[i];
            core_dout_vld = 1'b1;
            tick();
            if (gapped) begin
                core_dout     = ~w[i];
                core_dout_vld = 1'b0;
                tick();
            end
        end
        core_dout_vld = 1'b0;
    endtask

    task automatic accept_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},  in_ready,  2'b00);
        check({tag, "_core_load"}, core_load, 1'b0);
        check({tag, "_core_data"}, core_data, 256'h0);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_data"},  out_data,  128'h0);
        check({tag, "_out_id"},    out_id,    1'b0);
        check({tag, "_out_err"},   out_err,   1'b0);
    endtask

    logic [127:0] w1, wg, wr;
    logic [255:0] da, db;
    int           k;
    logic         exp_id;

    initial begin
        reset = 1'b1;
        in_valid = 2'b00; in_data0 = '0; in_data1 = '0;
        core_busy = 1'b0; core_dout = 1'b0; core_dout_vld = 1'b0; out_ready = 1'b0;
        t_in_valid = 2'b00; t_in_data0 = '0; t_in_data1 = '0;
        t_core_dout = 1'b0; t_core_dout_vld = 1'b0; t_out_ready = 1'b0;
        tick(); tick();
        check_all_zero("reset");
        reset = 1'b0;

        // Single job from requester 0.
        w1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEBEEF;
        in_data0 = 256'h1;
        in_valid = 2'b01;
        #1;
        check("single_in_ready", in_ready, 2'b01);
        tick();
        in_valid = 2'b00;
        check("single_core_load", core_load, 1'b1);
        check("single_core_data", core_data, 256'h1);
        check("single_in_ready_load", in_ready, 2'b00);
        tick();
        check("single_core_load_run", core_load, 1'b0);
        send_word(w1, 1'b0, 127);
        check("single_not_early", out_valid, 1'b0);
        send_word({w1[0], 127'h0}, 1'b0, 1);
        check("single_out_valid", out_valid, 1'b1);
        check("single_out_data", out_data, w1);
        check("single_out_id", out_id, 1'b0);
        check("single_out_err", out_err, 1'b0);
        accept_result();

        // Contention from reset: order 0,1,0,1, with backpressure on the second job.
        reset = 1'b1; tick(); reset = 1'b0;
        da = {8{32'hAAAA0000}};
        db = {8{32'hBBBB1111}};
        in_data0 = da; in_data1 = db;
        in_valid = 2'b11;
        for (int j = 0; j < 4; j++) begin
            exp_id = 1'(j & 1);
            #1;
            check("cont_in_ready", in_ready, exp_id ? 2'b10 : 2'b01);
            tick();
            check("cont_core_data", core_data, exp_id ? db : da);
            tick();
            send_word({4{32'h12345600 + 32'(j)}}, 1'b0, 128);
            check("cont_out_id", out_id, exp_id);
            check("cont_out_data", out_data, {4{32'h12345600 + 32'(j)}});
            if (j == 1) begin
                for (int c = 0; c < 20; c++) begin
                    tick();
                    check("bp_out_valid", out_valid, 1'b1);
                    check("bp_out_data", out_data, {4{32'h12345601}});
                    check("bp_in_ready", in_ready, 2'b00);
                end
            end
            accept_result();
        end
        in_valid = 2'b00;

        // Gapped stream with five surplus bits after the 128th.
        wg = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
        in_data0 = 256'h55;
        in_valid = 2'b01;
        #1;
        check("gap_in_ready", in_ready, 2'b01);
        tick();
        in_valid = 2'b00;
        tick();
        send_word(wg, 1'b1, 128);
        for (int e = 0; e < 5; e++) begin
            core_dout = 1'($urandom);
            core_dout_vld = 1'b1;
            tick();
        end
        core_dout_vld = 1'b0;
        check("gap_out_valid", out_valid, 1'b1);
        check("gap_out_data", out_data, wg);
        check("gap_out_err", out_err, 1'b0);
        accept_result();

        // Reset while in RUN after 60 bits, then a clean job from requester 1.
        in_data0 = 256'h77;
        in_valid = 2'b01;
        tick();
        in_valid = 2'b00;
        tick();
        send_word(~w1, 1'b0, 60);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("midreset");
        wr = 128'h13579BDF_2468ACE0_FEDCBA98_76543210;
        in_data1 = 256'h99;
        in_valid = 2'b10;
        #1;
        check("post_in_ready", in_ready, 2'b10);
        tick();
        in_valid = 2'b00;
        check("post_core_data", core_data, 256'h99);
        tick();
        send_word(wr, 1'b0, 127);
        check("post_not_early", out_valid, 1'b0);
        send_word({wr[0], 127'h0}, 1'b0, 1);
        check("post_out_valid", out_valid, 1'b1);
        check("post_out_data", out_data, wr);
        check("post_out_id", out_id, 1'b1);
        accept_result();

        // Watchdog: TIMEOUT=50 instance, only 10 bits supplied.
        t_in_data0 = 256'h5;
        t_in_valid = 2'b01;
        tick();
        t_in_valid = 2'b00;
        check("to_core_load", t_core_load, 1'b1);
        tick();
        k = 0;
        while (!t_out_valid && k < 200) begin
            t_core_dout     = 1'b1;
            t_core_dout_vld = (k < 10);
            tick();
            k++;
        end
        t_core_dout_vld = 1'b0;
        check("to_latency", 32'(k), 32'd50);
        check("to_out_valid", t_out_valid, 1'b1);
        check("to_out_err", t_out_err, 1'b1);
        check("to_out_data", t_out_data, 128'h0);
        t_out_ready = 1'b1;
        tick();
        t_out_ready = 1'b0;
        check("to_out_valid_drop", t_out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gp_arbiter.md
GP_ARBITER -- requirements
Module: gp_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023, meaning the maximum number of cycles spent in RUN before the job is aborted.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports in_valid, input, 2 bits, and in_ready, output, 2 bits: per-requester handshake; bit i belongs to requester i.
REQ-005 SHALL have ports in_data0 and in_data1, input, 256 bits each: the job word for each requester.
REQ-006 SHALL have port core_load, output, 1 bit: one-cycle start pulse to the grasspopper core.
REQ-007 SHALL have port core_data, output, 256 bits: registered job word driven to the core's data_i.
REQ-008 SHALL have port core_busy, input, 1 bit: core busy flag, used for status only.
REQ-009 SHALL have ports core_dout and core_dout_vld, input, 1 bit each: core serial output, MSB first, qualified by core_dout_vld.
REQ-010 SHALL have ports out_valid, output, 1 bit, and out_ready, input, 1 bit: result handshake.
REQ-011 SHALL have ports out_data, output, 128 bits; out_id, output, 1 bit; out_err, output, 1 bit: the result word, the index of the requester it belongs to, and a timeout flag.

Function
REQ-012 SHALL implement the FSM states IDLE, LOAD, RUN and DONE.
REQ-013 In IDLE with any in_valid bit high, SHALL grant exactly one requester: the one not equal to last_grant when both are valid, otherwise the only valid one.
REQ-014 SHALL assert in_ready[g] combinationally only in the IDLE cycle of grant; on that edge it latches in_data_g into core_data, records g, clears the bit counter and the watchdog, and moves to LOAD.
REQ-015 SHALL assert core_load for exactly one cycle in LOAD, then move to RUN; core_load SHALL be 0 in every other state.
REQ-016 In RUN, each cycle with core_dout_vld=1 SHALL shift core_dout into the LSB of a 128-bit shift register and increment a 7-bit counter.
REQ-017 On the 128th valid bit, SHALL move to DONE with out_err=0, so the first received bit ends up in out_data[127].
REQ-018 SHALL count RUN cycles in the watchdog; when the watchdog reaches TIMEOUT before 128 bits are received, SHALL move to DONE with out_err=1 and out_data=0.
REQ-019 In DONE, SHALL hold out_valid=1 with out_data, out_id and out_err stable until out_valid and out_ready are high on the same edge; that edge sets last_grant to out_id and returns to IDLE.
REQ-020 SHALL ignore core_dout_vld in IDLE, LOAD and DONE, and SHALL ignore bits beyond the 128th.
REQ-021 SHALL grant no new job while in LOAD, RUN or DONE, so in_ready=0 there; a requester that keeps in_valid high simply waits.
REQ-022 Latency: in_valid granted in cycle N gives core_load in cycle N+1; out_valid rises one cycle after the 128th valid bit.
REQ-023 SHALL use in_valid only as a request; dropping in_valid before grant withdraws the request without side effects.

Reset
REQ-024 On reset=1, SHALL set the state to IDLE and drive in_ready=0, core_load=0, core_data=0, out_valid=0, out_data=0, out_id=0, out_err=0, with counter and watchdog at 0.
REQ-025 On reset=1, SHALL set last_grant=1 so that requester 0 wins the first contention.
REQ-026 Reset mid-operation (any state) SHALL abort the job immediately, with no result emitted and no wait on core_busy.

Structure
REQ-027 Package gp_pkg SHALL hold the state enum type, GP_KEY_W=256, GP_BLK_W=128 and GP_CNT_W=7.
REQ-028 The 128-bit shift register and bit counter SHALL be one sub-module, gp_deser, with ports clk, reset, clr, bit_i, vld_i, data_o and done_o.
REQ-029 The FSM, arbitration and watchdog SHALL reside in gp_arbiter.

Verification
REQ-030 Single job: in_valid=2'b01 with in_data0=256'h1 -> core_load pulses one cycle later; 128 core bits forming 128'hDEAD...BEEF -> out_valid with that out_data, out_id=0, out_err=0.
REQ-031 Contention: in_valid=2'b11 held after reset -> grant order 0,1,0,1 over four jobs; out_id follows the same order.
REQ-032 Backpressure: out_ready=0 for 20 cycles in DONE -> out_valid and out_data remain stable; in_ready stays 0 throughout.
REQ-033 Timeout: TIMEOUT=50 and only 10 bits supplied -> out_valid exactly 50 cycles after RUN entry, with out_err=1 and out_data=0.
REQ-034 Gapped stream: core_dout_vld toggling 1/0, plus 5 extra bits after the 128th -> correct out_data; the extra bits are ignored.
REQ-035 Reset in RUN after 60 bits -> IDLE with all outputs 0 the next cycle; the following job completes correctly with a fresh count.
